rv32_decode: RTL

- Registered RV32I instruction decode stage. Accepts a fetched instruction word plus its PC over a valid/ready handshake.
- Produces the control bundle consumed by the execute-stage ALU: ALUop class, func3, func7 bit, sign-extended immediate, register indices, and memory/writeback enables.
- Sits between fetch and execute. Holds exactly one decoded instruction in an output register, with backpressure and flush support.

---
 rtl/rv32_decode.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/rv32_decode.sv
// RV32I decode stage: one-entry registered output slot holding the ALU control bundle,
// with valid/ready handshakes on both sides and a flush that drops held and incoming work.
module rv32_decode #(
    parameter int PC_BITS  = 32,
    parameter int CNT_BITS = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_instr,
    input  logic [PC_BITS-1:0]  i_pc,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [PC_BITS-1:0]  o_pc,
    output logic [PC_BITS-1:0]  o_npc,
    output logic [2:0]          o_ALUop,
    output logic [2:0]          o_func3,
    output logic                o_func7,
    output logic [31:0]         o_imm,
    output logic [4:0]          o_rs1,
    output logic [4:0]          o_rs2,
    output logic [4:0]          o_rd,
    output logic                o_reg_we,
    output logic                o_mem_rd,
    output logic                o_mem_wr,
    output logic                o_illegal,
    output logic [CNT_BITS-1:0] o_dec_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
    logic [2:0]  w_aluop;
    logic [31:0] w_imm;
    logic        w_func7, w_we, w_mr, w_mw, w_ill;
    logic        w_accept, w_consume;

    logic                r_valid;
    logic [PC_BITS-1:0]  r_pc, r_npc;
    logic [2:0]          r_aluop, r_func3;
    logic                r_func7;
    logic [31:0]         r_imm;
    logic [4:0]          r_rs1, r_rs2, r_rd;
    logic                r_we, r_mr, r_mw, r_ill;
    logic [CNT_BITS-1:0] r_count;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_rd     = i_instr[11:7];

    assign w_immI = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_immS = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_immB = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_immU = {i_instr[31:12], 12'b0};
    assign w_immJ = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Opcodes whose low bits are not 11 never match the table, so they land in default as illegal.
    always_comb begin
        w_aluop = 3'd0;
        w_imm   = 32'd0;
        w_func7 = 1'b0;
        w_we    = 1'b0;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_ill   = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_aluop = 3'd2;
                w_we    = 1'b1;
                w_func7 = i_instr[30];
                if (w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                    w_ill = 1'b1;
                else if (w_f7 == 7'b0100000 && w_f3 != 3'd0 && w_f3 != 3'd5)
                    w_ill = 1'b1;
            end
            OP_IMM: begin
                w_aluop = 3'd3;
                w_we    = 1'b1;
                w_imm   = w_immI;
                if (w_f3 == 3'd1) begin
                    w_imm   = {27'b0, i_instr[24:20]};
                    w_func7 = i_instr[30];
                    w_ill   = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'd5) begin
                    w_imm   = {27'b0, i_instr[24:20]};
                    w_func7 = i_instr[30];
                    w_ill   = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end
            end
            OP_LOAD: begin
                w_we  = 1'b1;
                w_mr  = 1'b1;
                w_imm = w_immI;
                w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
            end
            OP_STORE: begin
                w_mw  = 1'b1;
                w_imm = w_immS;
                w_ill = (w_f3 > 3'd2);
            end
            OP_BRANCH: begin
                w_aluop = 3'd1;
                w_imm   = w_immB;
                w_ill   = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            OP_LUI: begin
                w_aluop = 3'd4;
                w_we    = 1'b1;
                w_imm   = w_immU;
            end
            OP_AUIPC: begin
                w_aluop = 3'd5;
                w_we    = 1'b1;
                w_imm   = w_immU;
            end
            OP_JAL: begin
                w_aluop = 3'd6;
                w_we    = 1'b1;
                w_imm   = w_immJ;
            end
            OP_JALR: begin
                w_aluop = 3'd7;
                w_we    = 1'b1;
                w_imm   = w_immI;
                w_ill   = (w_f3 != 3'd0);
            end
            OP_FENCE: begin
                w_aluop = 3'd3;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    assign o_ready   = !r_valid || i_ready;
    assign w_accept  = i_valid && o_ready && !i_flush;
    assign w_consume = r_valid && i_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_npc   <= '0;
            r_aluop <= '0;
            r_func3 <= '0;
            r_func7 <= 1'b0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_ill   <= 1'b0;
            r_count <= '0;
        end else begin
            if (i_flush)
                r_valid <= 1'b0;
            else if (w_accept)
                r_valid <= 1'b1;
            else if (i_ready)
                r_valid <= 1'b0;

            if (w_consume)
                r_count <= r_count + CNT_BITS'(1);

            // Illegal instructions still present a bundle but must never write state.
            if (w_accept) begin
                r_pc    <= i_pc;
                r_npc   <= i_pc + PC_BITS'(4);
                r_aluop <= w_aluop;
                r_func3 <= w_f3;
                r_func7 <= w_func7;
                r_imm   <= w_imm;
                r_rs1   <= i_instr[19:15];
                r_rs2   <= i_instr[24:20];
                r_rd    <= w_rd;
                r_we    <= w_we && !w_ill && (w_rd != 5'd0);
                r_mr    <= w_mr && !w_ill;
                r_mw    <= w_mw && !w_ill;
                r_ill   <= w_ill;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_pc        = r_pc;
    assign o_npc       = r_npc;
    assign o_ALUop     = r_aluop;
    assign o_func3     = r_func3;
    assign o_func7     = r_func7;
    assign o_imm       = r_imm;
    assign o_rs1       = r_rs1;
    assign o_rs2       = r_rs2;
    assign o_rd        = r_rd;
    assign o_reg_we    = r_we;
    assign o_mem_rd    = r_mr;
    assign o_mem_wr    = r_mw;
    assign o_illegal   = r_ill;
    assign o_dec_count = r_count;

endmodule
